// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine: FSM state encoding and first-index constants.
package regfile_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CSUM,
        FIN
    } dump_state_t;

    localparam int unsigned FIRST_IDX_ALL  = 0;
    localparam int unsigned FIRST_IDX_SKIP = 1;

    function automatic int unsigned first_idx(input bit skip_x0);
        return skip_x0 ? FIRST_IDX_SKIP : FIRST_IDX_ALL;
    endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Streams the integer register file out as indexed words on a valid/ready port.
// Define DUMP_CSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SKIP_X0 = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] RF_A,
    input  logic [DATA_W-1:0] RF_RD,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [ADDR_W-1:0] OUT_IDX,
    output logic              OUT_LAST,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(first_idx(SKIP_X0 != 0));
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NREGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
`ifdef DUMP_CSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef DUMP_CSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef DUMP_CSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        valid_d = valid_q;
        last_d  = last_q;
`ifdef DUMP_CSUM_EN
        acc_d   = acc_q;
`endif
        if (ABORT) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        idx_d   = IDX_FIRST;
`ifdef DUMP_CSUM_EN
                        acc_d   = '0;
`endif
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    data_d  = RF_RD;
                    oidx_d  = idx_q;
                    valid_d = 1'b1;
`ifdef DUMP_CSUM_EN
                    acc_d   = acc_q ^ RF_RD;
                    last_d  = 1'b0;
`else
                    last_d  = (idx_q == IDX_LAST);
`endif
                    state_d = SEND;
                end
                SEND: begin
                    if (OUT_READY) begin
                        valid_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
`ifdef DUMP_CSUM_EN
                            state_d = CSUM;
`else
                            state_d = FIN;
`endif
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
`ifdef DUMP_CSUM_EN
                // First CSUM cycle loads the checksum word; it then waits for its handshake.
                CSUM: begin
                    if (!valid_q) begin
                        data_d  = acc_q;
                        oidx_d  = '0;
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                    end else if (OUT_READY) begin
                        valid_d = 1'b0;
                        state_d = FIN;
                    end
                end
`endif
                FIN: begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign RF_A      = idx_q;
    assign OUT_VALID = valid_q;
    assign OUT_DATA  = data_q;
    assign OUT_IDX   = oidx_q;
    assign OUT_LAST  = last_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader (full dump and SKIP_X0 instances side by side).
module tb_regfile_dump_reader;

`ifdef DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
    localparam int CS_EXTRA = 2;
`else
    localparam bit CSUM_ON = 1'b0;
    localparam int CS_EXTRA = 0;
`endif
    localparam int DONE_FULL = 65 + CS_EXTRA;
    localparam int DONE_SKIP = 63 + CS_EXTRA;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } word_t;

    logic        CLK;
    logic        rst_n;
    logic        ready;
    logic        abort;
    logic        start   [2];
    logic [4:0]  rf_a    [2];
    logic [31:0] rf_rd   [2];
    logic        o_valid [2];
    logic [31:0] o_data  [2];
    logic [4:0]  o_idx   [2];
    logic        o_last  [2];
    logic        busy    [2];
    logic        done    [2];

    logic [31:0] rf [32];
    word_t       expq[$];
    int          vectors = 0;
    int          miscompares = 0;

    for (genvar g = 0; g < 2; g++) begin : gd
        regfile_dump_reader #(
            .NREGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(g)
        ) dut (
            .CLK(CLK), .RST_N(rst_n), .START(start[g]), .ABORT(abort),
            .RF_A(rf_a[g]), .RF_RD(rf_rd[g]),
            .OUT_VALID(o_valid[g]), .OUT_READY(ready), .OUT_DATA(o_data[g]),
            .OUT_IDX(o_idx[g]), .OUT_LAST(o_last[g]), .BUSY(busy[g]), .DONE(done[g])
        );
        assign rf_rd[g] = rf[rf_a[g]];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: the words a dump must emit, derived straight from the register contents.
    task automatic build_expected(input int first);
        logic [31:0] acc;
        acc = '0;
        expq.delete();
        for (int i = first; i < 32; i++) begin
            expq.push_back('{data: rf[i], idx: 5'(i), last: (i == 31) && !CSUM_ON});
            acc ^= rf[i];
        end
        if (CSUM_ON) expq.push_back('{data: acc, idx: 5'd0, last: 1'b1});
    endtask

    function automatic logic draw(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // kill_idx >= 0 abandons the dump (ABORT, or reset if kill_rst) while that index is on the port.
    task automatic run_dump(input int d, input int rdy_pct, input int start_noise,
                            input int done_cyc, input int kill_idx, input bit kill_rst);
        logic        pv, pr, plast;
        logic [31:0] pdata;
        logic [4:0]  pidx;
        int          cyc, nrx, nexp;
        bit          seen_valid, killed, done_seen;
        build_expected(d);
        nexp = expq.size();
        nrx = 0; seen_valid = 0; killed = 0; done_seen = 0;
        start[d] = 1'b1;
        ready = draw(rdy_pct);
        pv = o_valid[d]; pr = ready; pdata = o_data[d]; pidx = o_idx[d]; plast = o_last[d];
        for (cyc = 1; cyc < 6000; cyc++) begin
            step();
            start[d] = 1'b0;
            if (killed) begin
                check("kill_valid", o_valid[d], 1'b0);
                check("kill_last", o_last[d], 1'b0);
                check("kill_busy", busy[d], 1'b0);
                check("kill_done", done[d], 1'b0);
                if (kill_rst) begin
                    check("rst_data", o_data[d], 32'h0);
                    check("rst_idx", o_idx[d], 5'h0);
                    check("rst_rf_a", rf_a[d], 5'h0);
                end
                rst_n = 1'b1;
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check("post_kill_done", done[d], 1'b0);
                    check("post_kill_busy", busy[d], 1'b0);
                end
                return;
            end
            if (pv && pr) begin
                if (expq.size() == 0) begin
                    check("extra_word", pidx, 5'h1f);
                end else begin
                    check("word_data", pdata, expq[0].data);
                    check("word_idx", pidx, expq[0].idx);
                    check("word_last", plast, expq[0].last);
                    void'(expq.pop_front());
                end
                nrx++;
            end else if (pv) begin
                check("hold_valid", o_valid[d], 1'b1);
                check("hold_data", o_data[d], pdata);
                check("hold_idx", o_idx[d], pidx);
                check("hold_last", o_last[d], plast);
            end
            if (o_valid[d] && !seen_valid) begin
                seen_valid = 1;
                if (done_cyc > 0) check("first_valid_cyc", cyc, 2);
            end
            if (done[d]) begin
                done_seen = 1;
                if (done_cyc > 0) check("done_cyc", cyc, done_cyc);
                check("words_rx", nrx, nexp);
                check("queue_left", expq.size(), 0);
                ready = 1'b0;
                step();
                check("done_pulse_len", done[d], 1'b0);
                check("idle_busy", busy[d], 1'b0);
                check("idle_last", o_last[d], 1'b0);
                check("idle_valid", o_valid[d], 1'b0);
                return;
            end
            if (kill_idx >= 0 && o_valid[d] && o_idx[d] == 5'(kill_idx)) begin
                ready = 1'b0;
                if (kill_rst) rst_n = 1'b0;
                else abort = 1'b1;
                killed = 1;
            end else begin
                ready = draw(rdy_pct);
                start[d] = draw(start_noise);
            end
            pv = o_valid[d]; pr = ready; pdata = o_data[d]; pidx = o_idx[d]; plast = o_last[d];
        end
        start[d] = 1'b0;
        check("done_timeout", done_seen, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; abort = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check("reset_valid", o_valid[d], 1'b0);
            check("reset_last", o_last[d], 1'b0);
            check("reset_busy", busy[d], 1'b0);
            check("reset_done", done[d], 1'b0);
            check("reset_data", o_data[d], 32'h0);
            check("reset_idx", o_idx[d], 5'h0);
            check("reset_rf_a", rf_a[d], 5'h0);
        end
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        run_dump(0, 100, 0, DONE_FULL, -1, 0);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(0, 30, 20, 0, -1, 0);

        run_dump(1, 100, 0, DONE_SKIP, -1, 0);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(1, 30, 10, 0, -1, 0);

        run_dump(0, 100, 0, 0, 10, 0);
        run_dump(0, 100, 0, DONE_FULL, -1, 0);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(0, 50, 10, 0, 20, 1);
        run_dump(0, 60, 0, 0, -1, 0);

        start[0] = 1'b1; abort = 1'b1;
        step();
        start[0] = 1'b0; abort = 1'b0;
        check("abort_beats_start_busy", busy[0], 1'b0);
        step();
        check("abort_beats_start_valid", o_valid[0], 1'b0);
        check("abort_beats_start_busy2", busy[0], 1'b0);

        for (int i = 0; i < 32; i++) rf[i] = i;
        run_dump(0, 100, 0, DONE_FULL, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
